// File: rtl/sram_pkg.sv
// Shared types and defaults for the 16-bit asynchronous SRAM controller.
// The phase counter width follows the wait-state count.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam int DEF_BASE_ADDR = 1024;
  localparam int HALF_W        = 16;
  localparam int SRAM_ADDR_W   = 18;

  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Sequences 32-bit MEM-stage loads/stores as two 16-bit SRAM phases and stalls the pipeline meanwhile.
// Optional one-word read cache enabled by defining SRAM_READ_HIT_EN.
module sram_controller
  import sram_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = HALF_W,
  parameter int WAIT_CYCLES = 1,
  parameter int BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  // state | meaning
  // IDLE  | waiting for rd_en/wr_en; request latched on acceptance
  // LOW   | low halfword phase, SRAM address {word,0}
  // HIGH  | high halfword phase, SRAM address {word,1}
  // DONE  | one-cycle completion, ready high, read_data valid

  localparam int CNT_W  = cnt_width(WAIT_CYCLES);
  localparam int WORD_W = ADDR_W - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                op_wr_q;
  logic [WORD_W-1:0]   word_q;
  logic [2*DATA_W-1:0] wdata_q;
  logic [2*DATA_W-1:0] rdata_q;
  logic [31:0]         offset;
  logic [WORD_W-1:0]   req_word;
  logic                req, accept, in_phase, phase_last, hit;
  logic                dq_oe;
  logic [DATA_W-1:0]   dq_out;
  logic                unused_addr_bits;

  assign offset           = address - 32'(BASE_ADDR);
  assign req_word         = offset[WORD_W+1:2];
  assign unused_addr_bits = ^{offset[31:WORD_W+2], offset[1:0]};

  assign req        = rd_en | wr_en;
  assign accept     = (state_q == IDLE) && req && !hit;
  assign in_phase   = (state_q == LOW) || (state_q == HIGH);
  assign phase_last = (cnt_q == LAST_CNT);
  assign ready      = !accept && !in_phase;

`ifdef SRAM_READ_HIT_EN
  logic              c_valid_q;
  logic [WORD_W-1:0] c_tag_q;
  logic [31:0]       c_data_q;

  assign hit       = (state_q == IDLE) && rd_en && !wr_en && c_valid_q && (c_tag_q == req_word);
  assign read_data = hit ? c_data_q : rdata_q;

  // Filled on completion only, so an aborted access never pollutes the entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_valid_q <= 1'b0;
      c_tag_q   <= '0;
      c_data_q  <= '0;
    end else if (state_q == DONE) begin
      c_valid_q <= 1'b1;
      c_tag_q   <= word_q;
      c_data_q  <= op_wr_q ? wdata_q : rdata_q;
    end
  end
`else
  assign hit       = 1'b0;
  assign read_data = rdata_q;
`endif

  always_comb begin
    state_d   = state_q;
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    SRAM_ADDR = '0;
    dq_oe     = 1'b0;
    dq_out    = '0;
    unique case (state_q)
      IDLE:    if (accept) state_d = LOW;
      LOW:     if (phase_last) state_d = HIGH;
      HIGH:    if (phase_last) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (in_phase) begin
      SRAM_CE_N = 1'b0;
      SRAM_UB_N = 1'b0;
      SRAM_LB_N = 1'b0;
      SRAM_ADDR = {word_q, state_q == HIGH};
      if (op_wr_q) begin
        dq_oe     = 1'b1;
        dq_out    = (state_q == HIGH) ? wdata_q[2*DATA_W-1:DATA_W] : wdata_q[DATA_W-1:0];
        // Early WE_N release gives data hold time before the address moves.
        SRAM_WE_N = (WAIT_CYCLES > 1) && phase_last;
      end else begin
        SRAM_OE_N = 1'b0;
      end
    end
  end

  assign SRAM_DQ = dq_oe ? dq_out : {DATA_W{1'bz}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_wr_q <= wr_en;
        word_q  <= req_word;
        wdata_q <= write_data;
        cnt_q   <= '0;
      end else if (in_phase) begin
        cnt_q <= phase_last ? '0 : cnt_q + 1'b1;
      end
      if (in_phase && !op_wr_q && phase_last) begin
        if (state_q == HIGH) rdata_q[2*DATA_W-1:DATA_W] <= SRAM_DQ;
        else                 rdata_q[DATA_W-1:0]        <= SRAM_DQ;
      end
`ifdef SRAM_READ_HIT_EN
      if (hit) rdata_q <= c_data_q;
`endif
    end
  end

  a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !((state_q == IDLE) && rd_en && wr_en))
    else $warning("sram_controller: rd_en and wr_en together, write takes precedence");

endmodule
